// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: fetch FSM states and
// default datapath widths used by the fetch unit and its bus interface.
package mips_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int PC_STEP            = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FULL  = 3'd3,
    DRAIN = 3'd4,
    FAULT = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of everything the fetch unit exchanges with the program counter,
// the instruction memory port and the decode stage. The master side is the
// fetch unit itself; the slave side is the surrounding core.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = mips_pkg::DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = mips_pkg::DEFAULT_DATA_WIDTH
);

  // program counter side
  logic [ADDR_WIDTH-1:0] pc_addr;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;

  // instruction memory side
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  // decode side
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic                  fetch_fault;

  modport master (
    input  pc_addr, redirect_valid, redirect_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  instr_ready,
    output next_pc,
    output imem_req, imem_addr,
    output instr_valid, instr, instr_pc, fetch_fault
  );

  modport slave (
    output pc_addr, redirect_valid, redirect_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output instr_ready,
    input  next_pc,
    input  imem_req, imem_addr,
    input  instr_valid, instr, instr_pc, fetch_fault
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one fetch at a time for the current PC,
// parks the returned word in a single-entry buffer for decode, and steers
// the PC (hold, advance by PC_STEP, or redirect) through next_pc.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = mips_pkg::DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = mips_pkg::DEFAULT_DATA_WIDTH,
  parameter int PC_STEP    = mips_pkg::PC_STEP
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  import mips_pkg::*;

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [ADDR_WIDTH-1:0] next_pc_mux;
  logic                  misaligned;
  logic                  req_issue;
  logic                  instr_valid_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] instr_pc_q;
  logic                  fetch_fault_q;

  // Word fetches need a word-aligned PC; anything else parks the unit in FAULT.
  assign misaligned = |bus.pc_addr[1:0];

  // Sequential successor of the address in flight; the add wraps naturally.
  assign seq_addr = req_addr + ADDR_WIDTH'(PC_STEP);

  // A request is only raised for an aligned PC that is not being replaced
  // this very cycle, so a redirect never launches a stale fetch.
  assign req_issue = (state == REQ) && !misaligned && !bus.redirect_valid;

  // Pick the address the PC loads on its next negedge: redirect wins, then
  // advance once the fetched word arrives, otherwise reload the same value.
  always_comb begin
    next_pc_mux = bus.pc_addr;
    if (bus.redirect_valid) begin
      next_pc_mux = bus.redirect_addr;
    end else if ((state == WAIT) && bus.imem_rvalid) begin
      next_pc_mux = seq_addr;
    end
  end

  assign bus.next_pc     = next_pc_mux;
  assign bus.imem_addr   = bus.pc_addr;
  assign bus.imem_req    = req_issue;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_fault = fetch_fault_q;

  // Fetch sequencer and decode buffer: one outstanding request, and every
  // granted request has its response either buffered or drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req_addr      <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end

        REQ: begin
          if (bus.redirect_valid) begin
            state <= REQ;
          end else if (misaligned) begin
            state         <= FAULT;
            fetch_fault_q <= 1'b1;
          end else if (req_issue && bus.imem_gnt) begin
            state    <= WAIT;
            req_addr <= bus.pc_addr;
          end
        end

        WAIT: begin
          if (bus.imem_rvalid && !bus.redirect_valid) begin
            state         <= FULL;
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= req_addr;
            instr_valid_q <= 1'b1;
          end else if (bus.redirect_valid && !bus.imem_rvalid) begin
            state <= DRAIN;
          end else if (bus.redirect_valid && bus.imem_rvalid) begin
            state <= REQ;
          end
        end

        DRAIN: begin
          if (bus.imem_rvalid) begin
            state <= REQ;
          end
        end

        FULL: begin
          if (bus.instr_ready || bus.redirect_valid) begin
            state         <= REQ;
            instr_valid_q <= 1'b0;
          end
        end

        FAULT: begin
          if (bus.redirect_valid) begin
            state         <= REQ;
            fetch_fault_q <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          instr_valid_q <= 1'b0;
          fetch_fault_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: models the program counter and
// a variable-latency instruction memory, and checks fetched instructions
// against a queue of expected (pc, word) pairs.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails = 0;
  int   memLatency = 1;
  int   n;
  exp_t expQ[$];

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Contents of the instruction memory as a function of the address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a ^ 32'h8C00_0000) + 32'h0000_1111;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_addr  = ra;
    bus.instr_ready    = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pushExp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = memWord(pc);
    expQ.push_back(e);
  endtask

  // Advance until the buffer shows an instruction (bounded), then score it
  task automatic waitInstr(input int budget, output int cycles);
    exp_t e;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!bus.instr_valid && cycles < budget);
    checkOutput("instr_valid_arrives", 32'(bus.instr_valid), 32'h1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("instr_word", bus.instr, e.word);
      checkOutput("instr_pc", bus.instr_pc, e.pc);
    end
  endtask

  // Program counter model: loads next_pc on every negedge, cleared by reset
  initial begin
    bus.pc_addr = 32'h0;
    forever begin
      @(negedge clk or negedge reset);
      if (!reset) bus.pc_addr = 32'h0;
      else        bus.pc_addr = bus.next_pc;
    end
  end

  // Instruction memory model: always grants, returns data memLatency cycles later
  initial begin
    logic        accepted;
    logic [31:0] capAddr;
    logic [31:0] pendAddr;
    logic        pending;
    int          cnt;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    pending  = 1'b0;
    pendAddr = 32'h0;
    capAddr  = 32'h0;
    cnt      = 0;
    forever begin
      @(negedge clk);
      #4;
      accepted = bus.imem_req && bus.imem_gnt;
      capAddr  = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      if (!reset) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          cnt--;
          if (cnt <= 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memWord(pendAddr);
            pending         = 1'b0;
          end
        end
        if (accepted) begin
          pendAddr = capAddr;
          cnt      = memLatency - 1;
          if (cnt <= 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memWord(pendAddr);
          end else begin
            pending = 1'b1;
          end
        end
      end
    end
  end

  // Watchdog so a stuck design still produces a verdict
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, failures so far %0d", fails);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main scenario sequence
  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    checkOutput("rst_instr", bus.instr, 32'h0);
    checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
    checkOutput("rst_fetch_fault", 32'(bus.fetch_fault), 32'h0);
    checkOutput("rst_imem_req", 32'(bus.imem_req), 32'h0);

    // First fetch from address 0, grant immediate, data one cycle later
    reset = 1'b1;
    pushExp(32'h0);
    tick();
    settle();
    checkOutput("first_req", 32'(bus.imem_req), 32'h1);
    checkOutput("first_req_addr", bus.imem_addr, 32'h0);
    tick();
    settle();
    checkOutput("rvalid_next_pc", bus.next_pc, 32'h4);
    waitInstr(10, n);

    // Decode stalls for 5 cycles: buffer stable, no requests, PC holds at 4
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", 32'(bus.instr_valid), 32'h1);
      checkOutput("stall_instr", bus.instr, 32'h2008_0005);
      checkOutput("stall_instr_pc", bus.instr_pc, 32'h0);
      settle();
      checkOutput("stall_req", 32'(bus.imem_req), 32'h0);
      checkOutput("stall_next_pc", bus.next_pc, 32'h4);
    end

    // Accept, then fetch 0x4: three cycles from accept to the next instruction
    applyStimulus(1'b0, 32'h0, 1'b1);
    pushExp(32'h4);
    waitInstr(10, n);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("seq_latency", 32'(n), 32'h3);

    // Redirect to 0x40 while waiting on a slow response for 0x8
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    memLatency = 3;
    tick();
    applyStimulus(1'b1, 32'h40, 1'b0);
    settle();
    checkOutput("wait_redirect_next_pc", bus.next_pc, 32'h40);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("drain_valid_0", 32'(bus.instr_valid), 32'h0);
    settle();
    checkOutput("drain_req", 32'(bus.imem_req), 32'h0);
    checkOutput("drain_next_pc", bus.next_pc, 32'h40);
    tick();
    checkOutput("drain_valid_1", 32'(bus.instr_valid), 32'h0);
    tick();
    checkOutput("drain_valid_2", 32'(bus.instr_valid), 32'h0);
    settle();
    checkOutput("refetch_req", 32'(bus.imem_req), 32'h1);
    checkOutput("refetch_addr", bus.imem_addr, 32'h40);
    pushExp(32'h40);
    waitInstr(20, n);
    memLatency = 1;

    // Redirect in FULL together with ready: flush, refetch at 0x80
    applyStimulus(1'b1, 32'h80, 1'b1);
    tick();
    checkOutput("flush_valid", 32'(bus.instr_valid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("flush_req", 32'(bus.imem_req), 32'h1);
    checkOutput("flush_addr", bus.imem_addr, 32'h80);
    pushExp(32'h80);
    waitInstr(10, n);

    // Redirect (no ready) to a misaligned PC: fault, sticky until redirect
    applyStimulus(1'b1, 32'h6, 1'b0);
    tick();
    checkOutput("misalign_flush_valid", 32'(bus.instr_valid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    settle();
    checkOutput("misalign_req", 32'(bus.imem_req), 32'h0);
    tick();
    checkOutput("fault_set", 32'(bus.fetch_fault), 32'h1);
    settle();
    checkOutput("fault_req", 32'(bus.imem_req), 32'h0);
    checkOutput("fault_next_pc", bus.next_pc, 32'h6);
    tick();
    checkOutput("fault_sticky", 32'(bus.fetch_fault), 32'h1);
    checkOutput("fault_valid", 32'(bus.instr_valid), 32'h0);
    applyStimulus(1'b1, 32'h100, 1'b0);
    settle();
    checkOutput("fault_redirect_next_pc", bus.next_pc, 32'h100);
    tick();
    checkOutput("fault_cleared", 32'(bus.fetch_fault), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    pushExp(32'h100);
    waitInstr(10, n);

    // Fetch at the top of the address space: successor wraps to 0
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    pushExp(32'hFFFF_FFFC);
    tick();
    settle();
    checkOutput("wrap_next_pc", bus.next_pc, 32'h0);
    waitInstr(10, n);

    // Decode always ready: one instruction every 3 cycles
    applyStimulus(1'b0, 32'h0, 1'b1);
    pushExp(32'h0);
    pushExp(32'h4);
    pushExp(32'h8);
    for (int i = 0; i < 3; i++) begin
      waitInstr(10, n);
      checkOutput("throughput_cycles", 32'(n), 32'h3);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Reset asserted mid-transaction clears everything asynchronously
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    memLatency = 3;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(bus.instr_valid), 32'h0);
    checkOutput("midrst_instr", bus.instr, 32'h0);
    checkOutput("midrst_instr_pc", bus.instr_pc, 32'h0);
    checkOutput("midrst_fault", 32'(bus.fetch_fault), 32'h0);
    checkOutput("midrst_req", 32'(bus.imem_req), 32'h0);
    tick();
    tick();
    memLatency = 1;
    reset = 1'b1;
    pushExp(32'h0);
    waitInstr(10, n);
    checkOutput("post_reset_latency", 32'(n), 32'h3);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
